// File: rtl/reduction_rr_sched.sv
// reduction_rr_sched: round-robin arbiter feeding one shared 1-bit reduction engine,
// returning id-tagged results over a valid/ready response channel.
module reduction_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW = 2,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_result,
  output logic [CNTW-1:0]          done_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] rr_ptr, win, nxt_ptr, id_q;
  logic [IDW:0] t;
  logic found;
  logic [WIDTH-1:0] a_q, b_q, sum, diff;
  logic [2:0] op_q;
  logic [7:0] ops;
  // first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    win = '0;
    t = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = {1'b0, rr_ptr} + (IDW+1)'(k);
      t = (t >= (IDW+1)'(NUM_REQ)) ? t - (IDW+1)'(NUM_REQ) : t;
      if (!found && req_valid[t[IDW-1:0]]) begin
        found = 1'b1;
        win = t[IDW-1:0];
      end
    end
  end
  assign req_ready = (state == IDLE && found) ? NUM_REQ'(1'b1) << win : '0;
  assign nxt_ptr = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign sum = a_q + b_q;
  assign diff = a_q - b_q;
  assign ops = {|diff, &sum, ^(a_q ^ b_q), |(a_q | b_q), &(a_q & b_q),
                ^a_q ^ ^b_q, |a_q & |b_q, &a_q | &b_q};
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (found ? EXEC : IDLE) :
              (state == EXEC) ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      rr_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= 1'b0;
      done_count <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      id_q <= '0;
    end else begin
      if (state == IDLE && found) begin
        a_q <= req_a[win*WIDTH +: WIDTH];
        b_q <= req_b[win*WIDTH +: WIDTH];
        op_q <= req_op[win*3 +: 3];
        id_q <= win;
        rr_ptr <= nxt_ptr;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id <= id_q;
        rsp_result <= ops[op_q];
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        done_count <= done_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_reduction_rr_sched.sv
// tb_reduction_rr_sched: randomized and directed stimulus against a behavioural
// arbitration/reduction model; responses checked from a scoreboard queue.
module tb_reduction_rr_sched;
  localparam int N = 4, W = 8, IDW = 2, CW = 16;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic rsp_valid, rsp_ready = 0, rsp_result;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0] done_count;
  typedef struct {int id; bit res;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  int phase = 0, ptr = 0, accepts = 0, acc0;
  bit prev_acc = 0, prev_rst = 0, prev_rr = 0;
  bit pstall = 0, pres = 0;
  logic [IDW-1:0] pid = '0;
  logic [CW-1:0] exp_done = '0;
  always #5 clk = ~clk;
  reduction_rr_sched #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .done_count(done_count));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit ref_op(int op, int a, int b);
    int m = (1 << W) - 1;
    bit all_a = (a == m), all_b = (b == m), any_a = (a != 0), any_b = (b != 0);
    int par = ($countones(a) + $countones(b)) % 2;
    case (op)
      0: return all_a || all_b;
      1: return any_a && any_b;
      2: return par == 1;
      3: return all_a && all_b;
      4: return any_a || any_b;
      5: return par == 1;
      6: return ((a + b) % (m + 1)) == m;
      default: return a != b;
    endcase
  endfunction
  // one clock of stimulus; the model tracks idle/exec/resp by cycle count
  task automatic step(bit rn, logic [N-1:0] v, logic [N*W-1:0] a, logic [N*W-1:0] b,
                      logic [N*3-1:0] op, bit rr);
    int win;
    logic [N-1:0] er;
    @(posedge clk);
    if (prev_rst) begin
      phase = 0;
      ptr = 0;
      sb.delete();
    end else if (prev_acc) phase = 1;
    else if (phase == 1) phase = 2;
    else if (phase == 2 && prev_rr) phase = 0;
    #2;
    rst_n = rn; req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = rr;
    #1;
    win = -1;
    er = '0;
    if (rn) begin
      if (prev_rst) begin
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset rsp_result", 32'(rsp_result), 0);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
      if (phase == 0)
        for (int k = 0; k < N; k++)
          if (win < 0 && v[(ptr + k) % N]) win = (ptr + k) % N;
      if (win >= 0) er[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (win >= 0) begin
        sb.push_back('{win, ref_op(int'(op[win*3 +: 3]), int'(a[win*W +: W]), int'(b[win*W +: W]))});
        ptr = (win + 1) % N;
        accepts++;
      end
    end
    prev_acc = (win >= 0);
    prev_rst = !rn;
    prev_rr = rr;
  endtask
  task automatic idle(int n);
    repeat (n) step(1, '0, '0, '0, '0, 1);
  endtask
  task automatic one(int id, int a, int b, int op);
    logic [N*W-1:0] av = '0, bv = '0;
    logic [N*3-1:0] ov = '0;
    av[id*W +: W] = W'(a);
    bv[id*W +: W] = W'(b);
    ov[id*3 +: 3] = 3'(op);
    step(1, N'(1) << id, av, bv, ov, 1);
    idle(3);
  endtask
  always @(negedge clk)
    if (!rst_n) begin
      exp_done = '0;
      pstall = 0;
    end else begin
      chk("done_count", 32'(done_count), 32'(exp_done));
      if (pstall) begin
        chk("hold rsp_valid", 32'(rsp_valid), 1);
        chk("hold rsp_id", 32'(rsp_id), 32'(pid));
        chk("hold rsp_result", 32'(rsp_result), 32'(pres));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected response: id %0d with no expected entry", rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
        end
        exp_done++;
      end
      pstall = rsp_valid && !rsp_ready;
      pid = rsp_id;
      pres = rsp_result;
    end
  initial begin
    logic [N*W-1:0] av, bv;
    logic [N*3-1:0] ov;
    step(0, '0, '0, '0, '0, 0);
    step(0, '0, '0, '0, '0, 0);
    idle(2);
    one(0, 'hFF, 'hFF, 0);
    one(2, 'h01, 'hFF, 6);
    one(2, 'h80, 'h7F, 6);
    one(2, 'h55, 'h55, 7);
    one(2, 'h00, 'h01, 7);
    // backpressure: 1 exec + 5 stalled resp cycles with every requester asking
    step(1, 4'b1000, $urandom, $urandom, 12'($urandom), 1);
    repeat (6) step(1, 4'b1111, $urandom, $urandom, 12'($urandom), 0);
    step(1, '0, '0, '0, '0, 1);
    idle(1);
    // operand isolation: requester 1 operand changes right after accept
    av = '0; bv = '0; ov = '0;
    av[W +: W] = 8'hFF; bv[W +: W] = 8'hFF; ov[3 +: 3] = 3'd3;
    step(1, 4'b0010, av, bv, ov, 1);
    av[W +: W] = 8'h00;
    step(1, '0, av, bv, ov, 1);
    idle(3);
    // reset while a response is pending
    step(1, 4'b0001, $urandom, $urandom, 12'($urandom), 0);
    step(1, '0, '0, '0, '0, 0);
    step(1, '0, '0, '0, '0, 0);
    step(0, '0, '0, '0, '0, 0);
    idle(1);
    acc0 = accepts;
    repeat (18) step(1, 4'b1111, $urandom, $urandom, 12'($urandom), 1);
    chk("fairness grants in 18 cycles", 32'(accepts - acc0), 6);
    repeat (2000)
      step(1, N'($urandom), $urandom, $urandom, 12'($urandom), $urandom_range(0, 3) != 0);
    idle(5);
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
